// File: rtl/pwm_compare_gen.sv
// pwm_compare_gen: compares a free-running upstream count against a
// double-buffered duty value and drives a registered PWM output whose period
// is the counter wrap period (2^W cycles). An enable FSM starts and stops the
// waveform only on wrap boundaries (cnt_in == 0), so every period is complete.
//
// Optional feature: define PWM_COMPARE_IRQ_EN to add a sticky period
// interrupt (irq) with a clear input (irq_clr). Without it irq is tied low
// and irq_clr does not exist.
//
// Handshake: there is no valid/ready pair. cnt_in is assumed valid on every
// posedge, duty_wr is a single-cycle strobe accepted unconditionally, and all
// outputs are registered and valid every cycle after reset.
//
// dbg_state exposes the FSM state for checkers:
// 0 = IDLE, 1 = ARM, 2 = RUN, 3 = DRAIN.

module pwm_compare_gen #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic [W-1:0] cnt_in,
    input  logic         duty_wr,
    input  logic [W-1:0] duty_in,
`ifdef PWM_COMPARE_IRQ_EN
    input  logic         irq_clr,
`endif
    output logic         pwm,
    output logic         busy,
    output logic         period_tick,
    output logic [W-1:0] duty_active,
    output logic         irq,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic         pwm_q, pwm_d;
    logic         busy_q, busy_d;
    logic         tick_q, tick_d;
    logic [W-1:0] duty_active_q, duty_active_d;
    logic [W-1:0] duty_shadow_q;
    logic         wrap;

    // A sampled zero count is a wrap, including repeated zeros while the
    // upstream counter is held in reset.
    assign wrap = (cnt_in == '0);

    // Shadow register: accepts writes in any state; the active copy only
    // picks it up on a wrap, so a write on the wrap edge lands one period later.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            duty_shadow_q <= '0;
        end else if (duty_wr) begin
            duty_shadow_q <= duty_in;
        end
    end

    // Next-state, next-pwm and duty reload decisions.
    always_comb begin
        state_d       = state_q;
        pwm_d         = 1'b0;
        duty_active_d = duty_active_q;
        tick_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ARM;
                end
            end

            ARM: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    // First period starts on the wrap edge itself; no tick here.
                    state_d       = RUN;
                    duty_active_d = duty_shadow_q;
                    pwm_d         = (duty_shadow_q != '0);
                end
            end

            RUN: begin
                tick_d = wrap;
                if (wrap) begin
                    duty_active_d = duty_shadow_q;
                    pwm_d         = (duty_shadow_q != '0);
                end else begin
                    pwm_d = (cnt_in < duty_active_q);
                end
                if (!en) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                tick_d = wrap;
                if (wrap) begin
                    duty_active_d = duty_shadow_q;
                    pwm_d         = (duty_shadow_q != '0);
                end else begin
                    pwm_d = (cnt_in < duty_active_q);
                end
                if (en) begin
                    state_d = RUN;
                end else if (wrap) begin
                    // Last period has finished; hold the line low from here.
                    state_d = IDLE;
                    pwm_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; synchronous active-low reset wins.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            pwm_q         <= 1'b0;
            busy_q        <= 1'b0;
            tick_q        <= 1'b0;
            duty_active_q <= '0;
        end else begin
            state_q       <= state_d;
            pwm_q         <= pwm_d;
            busy_q        <= busy_d;
            tick_q        <= tick_d;
            duty_active_q <= duty_active_d;
        end
    end

`ifdef PWM_COMPARE_IRQ_EN
    logic irq_q, irq_d;

    // Sticky interrupt: a new period boundary beats a simultaneous clear.
    always_comb begin
        irq_d = irq_q;
        if (tick_d) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    // Interrupt register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign pwm         = pwm_q;
    assign busy        = busy_q;
    assign period_tick = tick_q;
    assign duty_active = duty_active_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/pwm_compare_gen.md
Name: pwm_compare_gen

Overview:
Downstream consumer of the free-running 4-bit up-counter. Compares the incoming count against a double-buffered duty register and produces a registered PWM output whose period equals the counter wrap period (2^W cycles).
An enable FSM aligns the start and stop of the PWM to counter wrap boundaries, so no partial periods are ever produced. Also emits a per-period tick.

Parameters:
W, 4, width of cnt_in, duty_in and the duty registers; must match the upstream counter width.

Ports:
clk  input  1  clock; all logic on posedge
rstn  input  1  reset, synchronous, active-low
en  input  1  PWM enable request; level-sensitive
cnt_in  input  W  count value from the upstream counter; wrap point is cnt_in == 0
duty_wr  input  1  write strobe for the duty shadow register
duty_in  input  W  new duty value (high cycles per period)
pwm  output  1  registered PWM output
busy  output  1  high whenever the FSM is not IDLE
period_tick  output  1  1-cycle pulse marking a completed or started period boundary while running
duty_active  output  W  duty value currently in effect
irq  output  1  sticky period interrupt; see Optional Feature

Behaviour:
- Reset (rstn low at a posedge): state=IDLE; pwm=0, busy=0, period_tick=0, irq=0, duty_shadow=0, duty_active=0. Reset overrides every other input, including mid-period.
- Inputs are sampled at posedge. Define wrap = (cnt_in == 0).
- duty_wr=1 loads duty_shadow<=duty_in, in any state.
- FSM states: IDLE, ARM, RUN, DRAIN.
- IDLE:
  - en=1 -> ARM.
  - pwm=0.
- ARM:
  - en=0 -> IDLE.
  - en=1 and wrap -> RUN, with duty_active<=duty_shadow and pwm<=(duty_shadow != 0).
  - Otherwise stay in ARM; pwm=0.
- RUN:
  - On wrap: duty_active<=duty_shadow and pwm<=(0 < duty_shadow). The new duty applies on the wrap edge itself.
  - Otherwise: pwm<=(cnt_in < duty_active).
  - en=0 -> DRAIN; the pwm update for that edge still occurs.
- DRAIN:
  - pwm continues as in RUN.
  - en=1 -> RUN with no gap.
  - en=0 and wrap -> IDLE with pwm<=0. The pwm low from the wrap edge onward, so the last period is complete.
- Latency: pwm reflects cnt_in sampled at the same edge (1 register stage). With a free-running counter, pwm is high for exactly duty_active cycles per 2^W-cycle period.
- Duty boundaries:
  - duty=0 -> pwm constantly 0.
  - duty=2^W-1 -> pwm high 2^W-1 of 2^W cycles; a 100% duty is not representable.
- Simultaneous duty_wr and wrap on the same edge: duty_active takes the old shadow value. The new value takes effect at the next wrap.
- period_tick <= wrap && state in {RUN, DRAIN}. It is not asserted on the ARM->RUN edge.
- busy <= (next_state != IDLE); registered, so it tracks the state.
- Upstream counter reset (cnt_in forced to 0 for several cycles): each sampled 0 counts as a wrap.
  - duty_active reloads on each such edge.
  - period_tick pulses each cycle.
  - pwm = (duty_shadow != 0).
  This is legal and required behaviour.

Optional Feature:
Macro PWM_COMPARE_IRQ_EN.
- Defined:
  - irq sets on any edge where period_tick is being set.
  - irq clears when input irq_clr (1 bit, added port) is high.
  - Set wins over a simultaneous clear.
  - irq resets to 0.
- Not defined: irq_clr port absent; irq tied to constant 0.

Test Plan:
- Reset, then hold en=1 with a free-running counter and duty_wr=1, duty_in=4 before the first wrap:
  - Expect ARM until cnt_in==0, then RUN.
  - pwm high for exactly 4 cycles (cnt 0..3) of every 16.
  - period_tick pulses every 16 cycles.
- Write duty_in=10 mid-period (cnt_in=7) while in RUN:
  - Current period keeps duty 4.
  - From the next wrap, pwm is high 10 of 16 cycles and duty_active=10.
- duty_wr with duty_in=0 asserted on the same edge as wrap:
  - duty_active keeps the old value for that period.
  - Next period pwm stays 0 for all 16 cycles.
- Drop en at cnt_in=2 with duty=8:
  - State goes DRAIN; pwm stays high through cnt 7 and low through cnt 15.
  - At the next wrap, IDLE with busy=0 and no pwm pulse.
  - Re-raise en during DRAIN instead: return to RUN with no gap.
- Assert rstn=0 in RUN at cnt_in=1 with pwm high:
  - Next edge: pwm=0, busy=0, duty_active=0, state IDLE.
- With PWM_COMPARE_IRQ_EN:
  - irq rises with the first period_tick and stays high while irq_clr=0.
  - irq_clr pulse clears it.
  - irq_clr coincident with a wrap leaves irq=1.
